rs232_mem_arbiter: RTL and testbench



---
 rtl/rs232_mem_arbiter.sv | 107 ++++++++++
 tb/tb_rs232_mem_arbiter.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/rs232_mem_arbiter.sv
// Single-port memory arbiter: round-robin between the RS232 core (A) and a debug host (B),
// plus an erase sequencer that fills the whole array with ERASE_VALUE.
module rs232_mem_arbiter #(
   parameter int               ADDR_W         = 14,
   parameter int               DATA_W         = 8,
   parameter logic [DATA_W-1:0] ERASE_VALUE   = '0,
   parameter bit               ERASE_ON_RESET = 1'b1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              erase_req,
   output logic              end_of_erase,
   input  logic              a_req,
   input  logic              a_write,
   input  logic [ADDR_W-1:0] a_addr,
   input  logic [DATA_W-1:0] a_wdata,
   output logic              a_ack,
   output logic [DATA_W-1:0] a_rdata,
   input  logic              b_req,
   input  logic              b_write,
   input  logic [ADDR_W-1:0] b_addr,
   input  logic [DATA_W-1:0] b_wdata,
   output logic              b_ack,
   output logic [DATA_W-1:0] b_rdata,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_write,
   output logic [DATA_W-1:0] mem_data_in,
   input  logic [DATA_W-1:0] mem_data_out
);

   typedef enum logic [2:0] {S_ERASE, S_IDLE, S_WR, S_RD_ADDR, S_RD_DATA, S_DONE} state_t;

   state_t            state;
   logic [ADDR_W-1:0] cnt;
   logic              last_grant;  // 1 = B
   logic              grant_b;
   logic              a_eff, b_eff, pick_b;

   // A requester whose ack is high this cycle is still holding a stale req.
   assign a_eff  = a_req & ~a_ack;
   assign b_eff  = b_req & ~b_ack;
   assign pick_b = b_eff & (~a_eff | ~last_grant);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state        <= ERASE_ON_RESET ? S_ERASE : S_IDLE;
         cnt          <= '0;
         last_grant   <= 1'b1;
         grant_b      <= 1'b0;
         end_of_erase <= 1'b0;
         mem_addr     <= '0;
         mem_write    <= 1'b0;
         mem_data_in  <= '0;
         a_ack        <= 1'b0;
         b_ack        <= 1'b0;
         a_rdata      <= '0;
         b_rdata      <= '0;
      end else begin
         mem_write <= 1'b0;
         a_ack     <= 1'b0;
         b_ack     <= 1'b0;
         case (state)
            S_ERASE: begin
               end_of_erase <= 1'b0;
               mem_addr     <= cnt;
               mem_data_in  <= ERASE_VALUE;
               mem_write    <= 1'b1;
               cnt          <= cnt + 1'b1;
               if (cnt == '1) state <= S_IDLE;
            end
            S_IDLE: begin
               if (erase_req) begin
                  end_of_erase <= 1'b0;
                  cnt          <= '0;
                  state        <= S_ERASE;
               end else begin
                  end_of_erase <= 1'b1;
                  if (a_eff | b_eff) begin
                     grant_b     <= pick_b;
                     last_grant  <= pick_b;
                     mem_addr    <= pick_b ? b_addr  : a_addr;
                     mem_data_in <= pick_b ? b_wdata : a_wdata;
                     state       <= (pick_b ? b_write : a_write) ? S_WR : S_RD_ADDR;
                  end
               end
            end
            S_WR: begin
               mem_write <= 1'b1;
               state     <= S_DONE;
            end
            S_RD_ADDR: state <= S_RD_DATA;
            S_RD_DATA: begin
               if (grant_b) b_rdata <= mem_data_out;
               else         a_rdata <= mem_data_out;
               state <= S_DONE;
            end
            S_DONE: begin
               if (grant_b) b_ack <= 1'b1;
               else         a_ack <= 1'b1;
               state <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_rs232_mem_arbiter.sv
// Scoreboard bench for rs232_mem_arbiter with a registered-read 16K x 8 memory model.
module tb_rs232_mem_arbiter;
   localparam int AW = 14, DW = 8, DEPTH = 1 << AW;

   logic          clk = 1'b0, rst = 1'b0;
   logic          erase_req = 1'b0, end_of_erase;
   logic          a_req = 1'b0, a_write = 1'b0, a_ack;
   logic [AW-1:0] a_addr = '0;
   logic [DW-1:0] a_wdata = '0, a_rdata;
   logic          b_req = 1'b0, b_write = 1'b0, b_ack;
   logic [AW-1:0] b_addr = '0;
   logic [DW-1:0] b_wdata = '0, b_rdata;
   logic [AW-1:0] mem_addr;
   logic          mem_write;
   logic [DW-1:0] mem_data_in, mem_data_out;

   rs232_mem_arbiter dut (
      .clk(clk), .rst(rst), .erase_req(erase_req), .end_of_erase(end_of_erase),
      .a_req(a_req), .a_write(a_write), .a_addr(a_addr), .a_wdata(a_wdata),
      .a_ack(a_ack), .a_rdata(a_rdata),
      .b_req(b_req), .b_write(b_write), .b_addr(b_addr), .b_wdata(b_wdata),
      .b_ack(b_ack), .b_rdata(b_rdata),
      .mem_addr(mem_addr), .mem_write(mem_write), .mem_data_in(mem_data_in),
      .mem_data_out(mem_data_out)
   );

   always #5 clk = ~clk;

   // Memory preloaded with 8'hFF so the erase is observable.
   logic [DW-1:0] memarr [DEPTH];
   bit            pre_done = 1'b0;
   always @(posedge clk) begin
      if (!pre_done) begin
         for (int i = 0; i < DEPTH; i++) memarr[i] <= 8'hFF;
         pre_done <= 1'b1;
      end else if (mem_write) memarr[mem_addr] <= mem_data_in;
      mem_data_out <= memarr[mem_addr];
   end

   int n_chk = 0, n_pass = 0;
   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   typedef struct packed {
      logic          wr;
      logic [AW-1:0] addr;
      logic [DW-1:0] data;
   } sb_t;
   sb_t sb_a[$], sb_b[$];

   bit rr_on = 1'b0, rr_exp = 1'b0;
   int rr_n = 0;

   task automatic pop(input bit pb);
      sb_t e;
      int  sz;
      sz = pb ? sb_b.size() : sb_a.size();
      if (sz == 0) begin
         chk("unexpected_ack", sz, 1);
         return;
      end
      e = pb ? sb_b.pop_front() : sb_a.pop_front();
      if (e.wr) chk("wr_data", memarr[e.addr], e.data);
      else      chk("rd_data", pb ? b_rdata : a_rdata, e.data);
      if (rr_on) begin
         chk("rr_order", pb, rr_exp);
         rr_exp = ~rr_exp;
         rr_n++;
      end
   endtask

   // Monitor: erase sweep order/length, ack exclusivity, scoreboard pops.
   int   erase_idx = 0, erase_bad = 0;
   logic eoe_q = 1'b0;
   always @(negedge clk) begin
      if (!rst) begin
         erase_idx = 0;
         erase_bad = 0;
         eoe_q     = 1'b0;
      end else begin
         if (mem_write && !end_of_erase) begin
            if (mem_addr != AW'(erase_idx) || mem_data_in != 8'h00) erase_bad++;
            erase_idx++;
         end
         if (end_of_erase && !eoe_q) begin
            chk("erase_cnt", erase_idx, DEPTH);
            chk("erase_order", erase_bad, 0);
            erase_idx = 0;
            erase_bad = 0;
         end
         eoe_q = end_of_erase;
         if (a_ack || b_ack) begin
            chk("one_ack", a_ack & b_ack, 0);
            chk("eoe_at_ack", end_of_erase, 1);
         end
         if (a_ack) pop(1'b0);
         if (b_ack) pop(1'b1);
      end
   end

   task automatic do_txn(input bit pb, input bit wr, input logic [AW-1:0] addr,
                         input logic [DW-1:0] data, output int lat, output int wr_at);
      sb_t e;
      bit  got;
      e.wr = wr; e.addr = addr; e.data = data;
      if (pb) begin
         sb_b.push_back(e);
         b_req = 1'b1; b_write = wr; b_addr = addr; b_wdata = data;
      end else begin
         sb_a.push_back(e);
         a_req = 1'b1; a_write = wr; a_addr = addr; a_wdata = data;
      end
      lat = 0; wr_at = 0; got = 1'b0;
      while (!got && lat < 40000) begin
         @(posedge clk); #1;
         lat++;
         if (mem_write && end_of_erase && wr_at == 0) wr_at = lat;
         got = pb ? b_ack : a_ack;
      end
      if (!got) chk("ack_timeout", got, 1);
      if (pb) b_req = 1'b0; else a_req = 1'b0;
   endtask

   task automatic wait_eoe();
      int n = 0;
      while (!end_of_erase && n < 20000) begin
         @(posedge clk); #1;
         n++;
      end
      chk("eoe_wait", end_of_erase, 1);
   endtask

   task automatic chk_reset(input string tag);
      chk({tag, "_addr"}, mem_addr, 0);
      chk({tag, "_wr"}, mem_write, 0);
      chk({tag, "_din"}, mem_data_in, 0);
      chk({tag, "_acks"}, {a_ack, b_ack}, 0);
      chk({tag, "_rdata"}, {a_rdata, b_rdata}, 0);
      chk({tag, "_eoe"}, end_of_erase, 0);
   endtask

   task automatic count_nonzero(output int nz);
      nz = 0;
      for (int i = 0; i < DEPTH; i++) if (memarr[i] != 8'h00) nz++;
   endtask

   initial begin
      int lat, wa, nz, k;
      #12;
      chk_reset("rst0");
      @(posedge clk); #1;
      rst = 1'b1;

      // Both requesters pending through the power-up erase, then round-robin.
      rr_on = 1'b1;
      fork
         begin
            int la, wb;
            for (int i = 0; i < 6; i++) begin
               do_txn(1'b0, 1'b1, AW'(i), DW'(8'h10 + i), la, wb);
               if (i == 0) chk("a_held_thru_erase", la > DEPTH, 1);
               @(posedge clk); #1;
            end
         end
         begin
            int lb, wb;
            for (int i = 0; i < 6; i++) begin
               if (i % 2 == 0) do_txn(1'b1, 1'b1, AW'(200 + i), DW'(8'h40 + i), lb, wb);
               else            do_txn(1'b1, 1'b0, AW'(199 + i), DW'(8'h3F + i), lb, wb);
               @(posedge clk); #1;
            end
         end
      join
      rr_on = 1'b0;
      chk("rr_acks", rr_n, 12);

      // Uncontended latency at the top address.
      @(posedge clk); #1;
      do_txn(1'b0, 1'b1, 14'h3FFF, 8'hA5, lat, wa);
      chk("wr_lat", lat, 3);
      chk("wr_strobe_at", wa, 2);
      @(posedge clk); #1;
      do_txn(1'b0, 1'b0, 14'h3FFF, 8'hA5, lat, wa);
      chk("rd_lat", lat, 4);

      // erase_req wins over a simultaneous request.
      @(posedge clk); #1;
      erase_req = 1'b1;
      fork
         begin
            @(posedge clk); #1;
            erase_req = 1'b0;
         end
      join_none
      do_txn(1'b0, 1'b0, 14'h3FFF, 8'h00, lat, wa);
      chk("a_after_erase", lat > DEPTH, 1);
      count_nonzero(nz);
      chk("all_erased", nz, 0);

      // Reset in the middle of an erase sweep.
      @(posedge clk); #1;
      do_txn(1'b1, 1'b0, 14'h0010, 8'h00, lat, wa);
      @(posedge clk); #1;
      do_txn(1'b1, 1'b1, 14'h0010, 8'h9C, lat, wa);
      @(posedge clk); #1;
      do_txn(1'b1, 1'b0, 14'h0010, 8'h9C, lat, wa);
      @(posedge clk); #1;
      erase_req = 1'b1;
      @(posedge clk); #1;
      erase_req = 1'b0;
      k = 0;
      while (!(mem_write && mem_addr == 14'd100) && k < 500) begin
         @(posedge clk); #1;
         k++;
      end
      chk("reach_addr100", mem_addr, 100);
      #2 rst = 1'b0;
      #1 chk_reset("rst_mid");
      @(posedge clk); #1;
      rst = 1'b1;
      wait_eoe();

      // Reset while a B read is in RD_DATA.
      @(posedge clk); #1;
      do_txn(1'b1, 1'b1, 14'h0055, 8'h77, lat, wa);
      @(posedge clk); #1;
      do_txn(1'b1, 1'b0, 14'h0055, 8'h77, lat, wa);
      @(posedge clk); #1;
      b_req = 1'b1; b_write = 1'b0; b_addr = 14'h0055;
      @(posedge clk);
      @(posedge clk);
      #2 rst = 1'b0;
      #1;
      chk("rd_rst_back", b_ack, 0);
      chk("rd_rst_bdata", b_rdata, 0);
      b_req = 1'b0;
      sb_a.delete();
      sb_b.delete();
      @(posedge clk); #1;
      rst = 1'b1;
      wait_eoe();
      @(posedge clk); #1;
      do_txn(1'b1, 1'b0, 14'h0055, 8'h00, lat, wa);
      chk("b_reissue_lat", lat, 4);
      @(posedge clk); #1;
      do_txn(1'b1, 1'b1, 14'h0055, 8'h3C, lat, wa);
      @(posedge clk); #1;
      do_txn(1'b1, 1'b0, 14'h0055, 8'h3C, lat, wa);
      repeat (3) @(posedge clk);
      chk("sb_drained", sb_a.size() + sb_b.size(), 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
